ds18b20_responder: RTL and testbench

Cycle-level 1-Wire slave that emulates a DS18B20 temperature sensor on the thermistor line, clocked from `clk_main` (50 MHz). It is the responder side of the 1-Wire master that drives the `Thermistor` pin. It lets the master and its UART printf path be exercised in simulation and on a second board without a physical sensor. Supported: reset/presence, Skip ROM, Convert T, and Read Scratchpad with a live Dallas CRC-8.

---
 rtl/ds18b20_responder.sv | 190 +++++++++++++++++++
 tb/tb_ds18b20_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ds18b20_responder.sv
// DS18B20 1-Wire slave emulator: bus reset/presence, Skip ROM, Convert T and
// Read Scratchpad with a live Dallas CRC-8, all timed in clk_main cycles.
module ds18b20_responder #(
  parameter int unsigned T_RST    = 24000,
  parameter int unsigned T_PDLY   = 1500,
  parameter int unsigned T_PRES   = 6000,
  parameter int unsigned T_SAMPLE = 1500,
  parameter int unsigned T_HOLD0  = 1500
) (
  input  logic        clk_main,
  input  logic        reset_n,
  input  logic        dq_in,
  output logic        dq_oe,
  input  logic [15:0] temp_in,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        cmd_err
);

  localparam int unsigned TMAX01 = (T_PDLY > T_PRES) ? T_PDLY : T_PRES;
  localparam int unsigned TMAX23 = (T_SAMPLE > T_HOLD0) ? T_SAMPLE : T_HOLD0;
  localparam int unsigned TMAX   = (TMAX01 > TMAX23) ? TMAX01 : TMAX23;
  localparam int unsigned CW     = $clog2(TMAX + 1);
  localparam int unsigned LW     = $clog2(T_RST + 1);

  typedef enum logic [2:0] {
    StIdle, StPresWait, StPresDrive, StRomCmd, StFuncCmd, StConv, StTxScratch, StHalt
  } state_e;

  state_e      state_q;
  logic [1:0]  sync_q;
  logic        prev_q;
  logic [LW-1:0] low_cnt_q;
  logic [CW-1:0] cnt_q;
  logic        busy_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  tx_cnt_q;
  logic [7:0]  crc_q;
  logic [15:0] temp_q;

  logic        dq_s, fall, rise, bus_rst, tx_bit, crc_fb;
  logic [63:0] scratch;
  logic [7:0]  byte_next;

  always_comb begin
    dq_s      = sync_q[1];
    fall      = prev_q & ~dq_s;
    rise      = ~prev_q & dq_s;
    bus_rst   = rise && (low_cnt_q >= LW'(T_RST));
    scratch   = {8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, temp_q};
    tx_bit    = tx_cnt_q[6] ? crc_q[0] : scratch[tx_cnt_q[5:0]];
    crc_fb    = crc_q[0] ^ tx_bit;
    byte_next = {dq_s, shift_q[7:1]};
  end

  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      sync_q    <= 2'b11;
      prev_q    <= 1'b1;
      low_cnt_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      tx_cnt_q  <= 7'd0;
      crc_q     <= 8'h00;
      temp_q    <= 16'h0550;
      dq_oe     <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_byte  <= 8'h00;
      cmd_err   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], dq_in};
      prev_q    <= dq_s;
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
      if (dq_s) begin
        low_cnt_q <= '0;
      end else if (low_cnt_q < LW'(T_RST)) begin
        low_cnt_q <= low_cnt_q + LW'(1);
      end

      if (bus_rst) begin
        // A long reset pulse wins over whatever the slave was doing.
        state_q   <= StPresWait;
        cnt_q     <= '0;
        busy_q    <= 1'b0;
        bit_cnt_q <= 3'd0;
        dq_oe     <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle, StHalt: begin
          end
          StPresWait: begin
            if (cnt_q == CW'(T_PDLY - 1)) begin
              state_q <= StPresDrive;
              cnt_q   <= '0;
              dq_oe   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          StPresDrive: begin
            if (cnt_q == CW'(T_PRES - 1)) begin
              state_q   <= StRomCmd;
              dq_oe     <= 1'b0;
              busy_q    <= 1'b0;
              bit_cnt_q <= 3'd0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          StRomCmd, StFuncCmd: begin
            if (!busy_q) begin
              if (fall) begin
                busy_q <= 1'b1;
                cnt_q  <= '0;
              end
            end else begin
              if (cnt_q < CW'(T_SAMPLE)) cnt_q <= cnt_q + CW'(1);
              if (cnt_q == CW'(T_SAMPLE - 1)) begin
                shift_q   <= byte_next;
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                  cmd_valid <= 1'b1;
                  cmd_byte  <= byte_next;
                  if (state_q == StRomCmd) begin
                    if (byte_next == 8'hCC) begin
                      state_q <= StFuncCmd;
                    end else begin
                      cmd_err <= 1'b1;
                      state_q <= StHalt;
                    end
                  end else if (byte_next == 8'h44) begin
                    temp_q  <= temp_in;
                    state_q <= StConv;
                  end else if (byte_next == 8'hBE) begin
                    crc_q    <= 8'h00;
                    tx_cnt_q <= 7'd0;
                    state_q  <= StTxScratch;
                  end else begin
                    cmd_err <= 1'b1;
                    state_q <= StHalt;
                  end
                end
              end else if (cnt_q >= CW'(T_SAMPLE) && dq_s) begin
                busy_q <= 1'b0;
              end
            end
          end
          StConv: begin
            // Conversion is instantaneous, so read slots always see a released line.
            if (!busy_q) begin
              if (fall) busy_q <= 1'b1;
            end else if (dq_s) begin
              busy_q <= 1'b0;
            end
          end
          StTxScratch: begin
            if (!busy_q) begin
              if (fall) begin
                busy_q   <= 1'b1;
                cnt_q    <= '0;
                dq_oe    <= ~tx_bit;
                tx_cnt_q <= tx_cnt_q + 7'd1;
                if (tx_cnt_q[6]) begin
                  crc_q <= {1'b0, crc_q[7:1]};
                end else begin
                  crc_q <= {1'b0, crc_q[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
                end
              end
            end else if (dq_oe) begin
              if (cnt_q == CW'(T_HOLD0 - 1)) begin
                dq_oe <= 1'b0;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end else if (dq_s) begin
              busy_q <= 1'b0;
              if (tx_cnt_q == 7'd72) state_q <= StHalt;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ds18b20_responder.sv
// Bench for ds18b20_responder: behavioural 1-Wire master with scaled timing, scoreboarded
// command reports and scratchpad bytes, reference Dallas CRC-8.
module tb_ds18b20_responder;

  localparam int unsigned T_RST    = 240;
  localparam int unsigned T_PDLY   = 15;
  localparam int unsigned T_PRES   = 60;
  localparam int unsigned T_SAMPLE = 15;
  localparam int unsigned T_HOLD0  = 15;

  logic        clk_main = 1'b0;
  logic        reset_n  = 1'b0;
  logic        master_low = 1'b0;
  logic        dq_line;
  logic        dq_oe;
  logic [15:0] temp_in = 16'h1234;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        cmd_err;

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cmd_q[$];

  // Open-drain bus: either side can pull low.
  assign dq_line = ~(master_low | dq_oe);

  ds18b20_responder #(
    .T_RST(T_RST), .T_PDLY(T_PDLY), .T_PRES(T_PRES), .T_SAMPLE(T_SAMPLE), .T_HOLD0(T_HOLD0)
  ) dut (
    .clk_main (clk_main),
    .reset_n  (reset_n),
    .dq_in    (dq_line),
    .dq_oe    (dq_oe),
    .temp_in  (temp_in),
    .cmd_valid(cmd_valid),
    .cmd_byte (cmd_byte),
    .cmd_err  (cmd_err)
  );

  always #5 clk_main = ~clk_main;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] b[8]);
    logic [7:0] c = 8'h00;
    logic fb;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[i][j];
        c  = c >> 1;
        if (fb) c = c ^ 8'h8C;
      end
    end
    return c;
  endfunction

  always @(negedge clk_main) begin
    if (reset_n) begin
      if (cmd_valid) begin
        if (cmd_q.size() == 0) check("cmd_unexpected", {24'h0, cmd_byte}, 32'h100);
        else check("cmd_byte", {24'h0, cmd_byte}, {24'h0, cmd_q.pop_front()});
      end
      if (cmd_err) err_seen++;
    end
  end

  task automatic write_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_main) master_low = 1'b1;
      repeat (b[i] ? 3 : 40) @(negedge clk_main);
      master_low = 1'b0;
      repeat (b[i] ? 47 : 10) @(negedge clk_main);
    end
  endtask

  task automatic write_cmd(input logic [7:0] b);
    cmd_q.push_back(b);
    write_byte(b);
  endtask

  task automatic read_bit(output logic v);
    @(negedge clk_main) master_low = 1'b1;
    repeat (4) @(negedge clk_main);
    master_low = 1'b0;
    repeat (4) @(negedge clk_main);
    v = dq_line;
    repeat (32) @(negedge clk_main);
  endtask

  task automatic read_check(input string tag);
    logic [7:0] b;
    logic v;
    for (int i = 0; i < 8; i++) begin
      read_bit(v);
      b[i] = v;
    end
    if (exp_q.size() == 0) check({tag, "_extra"}, {24'h0, b}, 32'h100);
    else check(tag, {24'h0, b}, {24'h0, exp_q.pop_front()});
  endtask

  task automatic bus_reset(input int low, output int dly, output int wid);
    @(negedge clk_main) master_low = 1'b1;
    repeat (low) @(negedge clk_main);
    master_low = 1'b0;
    dly = -1;
    wid = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk_main);
      if (dq_oe) begin
        dly = i;
        break;
      end
    end
    if (dly >= 0) begin
      while (dq_oe && wid < 500) begin
        @(negedge clk_main);
        wid++;
      end
    end
    repeat (10) @(negedge clk_main);
  endtask

  task automatic reset_expect_presence(input string tag);
    int d, w;
    bus_reset(250, d, w);
    check({tag, "_pres_dly"}, d, T_PDLY + 3);
    check({tag, "_pres_wid"}, w, T_PRES);
  endtask

  task automatic push_scratch(input logic [15:0] t);
    logic [7:0] s[8];
    s = '{t[7:0], t[15:8], 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10};
    for (int i = 0; i < 8; i++) exp_q.push_back(s[i]);
    exp_q.push_back(crc8(s));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, w;
    logic v;
    logic [3:0] nib;

    repeat (3) @(negedge clk_main);
    check("rst_dq_oe", dq_oe, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_byte", cmd_byte, 0);
    check("rst_cmd_err", cmd_err, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_main);

    // Short low pulse is not a bus reset.
    bus_reset(50, d, w);
    check("short_no_pres", d, -1);

    // Power-up scratchpad; the classic 85 C image carries CRC 0x1C.
    reset_expect_presence("r1");
    write_cmd(8'hCC);
    write_cmd(8'hBE);
    foreach (exp_q[i]) ;
    exp_q.push_back(8'h50); exp_q.push_back(8'h05); exp_q.push_back(8'h4B);
    exp_q.push_back(8'h46); exp_q.push_back(8'h7F); exp_q.push_back(8'hFF);
    exp_q.push_back(8'h0C); exp_q.push_back(8'h10); exp_q.push_back(8'h1C);
    for (int i = 0; i < 9; i++) read_check("sp_pwrup");

    // Convert T latches temp_in; read slots during conversion read 1.
    temp_in = 16'h0191;
    reset_expect_presence("r2");
    write_cmd(8'hCC);
    write_cmd(8'h44);
    temp_in = 16'hABCD;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hFF);
    for (int i = 0; i < 4; i++) read_check("conv_ones");
    reset_expect_presence("r3");
    write_cmd(8'hCC);
    write_cmd(8'hBE);
    push_scratch(16'h0191);
    for (int i = 0; i < 9; i++) read_check("sp_conv");

    // Unsupported ROM command halts the slave until the next bus reset.
    reset_expect_presence("r4");
    write_cmd(8'h33);
    check("err_count", err_seen, 1);
    for (int i = 0; i < 2; i++) exp_q.push_back(8'hFF);
    for (int i = 0; i < 2; i++) read_check("halt_idle");

    // Bus reset at bit 20 of the scratchpad aborts; a fresh read restarts at byte 0.
    reset_expect_presence("r5");
    write_cmd(8'hCC);
    write_cmd(8'hBE);
    exp_q.push_back(8'h91);
    exp_q.push_back(8'h01);
    for (int i = 0; i < 2; i++) read_check("sp_partial");
    for (int i = 0; i < 4; i++) begin
      read_bit(v);
      nib[i] = v;
    end
    check("sp_partial_nib", nib, 4'hB);
    reset_expect_presence("r6");
    write_cmd(8'hCC);
    write_cmd(8'hBE);
    push_scratch(16'h0191);
    for (int i = 0; i < 9; i++) read_check("sp_restart");

    // reset_n during presence drops dq_oe at once and restores the 85 C image.
    @(negedge clk_main) master_low = 1'b1;
    repeat (250) @(negedge clk_main);
    master_low = 1'b0;
    for (int i = 0; i < 100 && !dq_oe; i++) @(negedge clk_main);
    check("pres_before_rst", dq_oe, 1);
    repeat (10) @(negedge clk_main);
    reset_n = 1'b0;
    #1;
    check("async_oe_drop", dq_oe, 0);
    check("async_cmd_byte", cmd_byte, 0);
    @(negedge clk_main) reset_n = 1'b1;
    repeat (5) @(negedge clk_main);
    write_byte(8'hCC);  // idle slave must not report this
    reset_expect_presence("r7");
    write_cmd(8'hCC);
    write_cmd(8'hBE);
    push_scratch(16'h0550);
    for (int i = 0; i < 9; i++) read_check("sp_after_rstn");

    repeat (20) @(negedge clk_main);
    check("exp_q_empty", exp_q.size(), 0);
    check("cmd_q_empty", cmd_q.size(), 0);
    check("err_total", err_seen, 1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
